// File: rtl/alu_pkg.sv
// Shared ALU constants: control codes, aluop encodings, R-type funct values
// and the EX sequencer state type, imported by the ALU, hazard unit and control.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_MUL = 3'b011;
    localparam logic [2:0] ALU_DIV = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;

    localparam logic [1:0] ALUOP_OR    = 2'b00;
    localparam logic [1:0] ALUOP_ADD   = 2'b01;
    localparam logic [1:0] ALUOP_SUB   = 2'b10;
    localparam logic [1:0] ALUOP_RTYPE = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_MUL = 6'b011000;
    localparam logic [5:0] FUNCT_DIV = 6'b011010;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } seqState_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Purely combinational aluop/funct decoder: yields the 3-bit ALU code, whether
// the op needs the multi-cycle unit, and whether an R-type funct is unsupported.
module alu_ctrl_decode
    import alu_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [5:0] funct_i,
    output logic [2:0] code_o,
    output logic       isMulti_o,
    output logic       illegal_o
);

    // Unsupported R-type functs fall back to ADD so downstream never sees X.
    always_comb begin
        code_o    = ALU_ADD;
        isMulti_o = 1'b0;
        illegal_o = 1'b0;
        case (aluop_i)
            ALUOP_OR:  code_o = ALU_OR;
            ALUOP_ADD: code_o = ALU_ADD;
            ALUOP_SUB: code_o = ALU_SUB;
            default: begin
                case (funct_i)
                    FUNCT_ADD: code_o = ALU_ADD;
                    FUNCT_SUB: code_o = ALU_SUB;
                    FUNCT_AND: code_o = ALU_AND;
                    FUNCT_OR:  code_o = ALU_OR;
                    FUNCT_MUL: begin
                        code_o    = ALU_MUL;
                        isMulti_o = 1'b1;
                    end
                    FUNCT_DIV: begin
                        code_o    = ALU_DIV;
                        isMulti_o = 1'b1;
                    end
                    default: illegal_o = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// EX-stage ALU control: combinational decode plus a sequencer that launches
// multi-cycle MUL/DIV, stalls the pipeline for LAT-1 cycles and flags done.
module alu_ctrl_seq
    import alu_pkg::*;
#(
    parameter int CTRL_W  = 3,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [1:0]        aluop_i,
    input  logic [5:0]        funct_i,
    input  logic              flush_i,
    output logic [CTRL_W-1:0] aluctrl_o,
    output logic              start_o,
    output logic              stall_o,
    output logic              done_o,
    output logic              busy_o,
    output logic              illegal_o
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    seqState_t        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [2:0]       latchedOp_q, latchedOp_d;

    logic [2:0] decCode;
    logic       decMulti;
    logic       decIllegal;
    logic [2:0] code;
    logic       launchMulti;

    alu_ctrl_decode uDecode (
        .aluop_i   (aluop_i),
        .funct_i   (funct_i),
        .code_o    (decCode),
        .isMulti_o (decMulti),
        .illegal_o (decIllegal)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            count_q     <= '0;
            latchedOp_q <= ALU_ADD;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            latchedOp_q <= latchedOp_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        latchedOp_d = latchedOp_q;
        code        = ALU_ADD;
        launchMulti = 1'b0;
        start_o     = 1'b0;
        stall_o     = 1'b0;
        done_o      = 1'b0;
        busy_o      = 1'b0;
        illegal_o   = 1'b0;
        case (state_q)
            IDLE: begin
                code      = decCode;
                illegal_o = valid_i & decIllegal;
                if (valid_i && decMulti && !flush_i) begin
                    start_o     = 1'b1;
                    latchedOp_d = decCode;
                    if (decCode == ALU_MUL) begin
                        count_d     = MUL_CNT;
                        launchMulti = (MUL_LAT > 1);
                    end else begin
                        count_d     = DIV_CNT;
                        launchMulti = (DIV_LAT > 1);
                    end
                    // A latency-1 op finishes in its launch cycle without stalling.
                    if (launchMulti) begin
                        stall_o = 1'b1;
                        state_d = BUSY;
                    end else begin
                        done_o = 1'b1;
                    end
                end
            end
            BUSY: begin
                code   = latchedOp_q;
                busy_o = 1'b1;
                if (flush_i) begin
                    state_d = IDLE;
                    count_d = '0;
                end else begin
                    if (count_q != '0) begin
                        count_d = count_q - CNT_ONE;
                    end
                    if (count_q > CNT_ONE) begin
                        stall_o = 1'b1;
                    end else begin
                        done_o  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset is asynchronous, so outputs must show reset values without an edge.
        if (rst_i) begin
            code      = ALU_ADD;
            start_o   = 1'b0;
            stall_o   = 1'b0;
            done_o    = 1'b0;
            busy_o    = 1'b0;
            illegal_o = 1'b0;
        end
    end

    assign aluctrl_o = CTRL_W'(code);

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed bench for alu_ctrl_seq: a decode vector table plus hand-written
// MUL/DIV sequencing, flush, async-reset and latency-1 sequences.
module tb_alu_ctrl_seq;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       valid_i;
    logic [1:0] aluop_i;
    logic [5:0] funct_i;
    logic       flush_i;

    logic [2:0] aluctrl;
    logic       start, stall, done, busy, illegal;
    logic [3:0] aluctrl1;
    logic       start1, stall1, done1, busy1, illegal1;

    int testsRun   = 0;
    int failCount  = 0;
    int stallCount = 0;

    typedef struct {
        string      name;
        logic       valid;
        logic [1:0] aluop;
        logic [5:0] funct;
        logic       flush;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[11];

    alu_ctrl_seq #(.CTRL_W(3), .MUL_LAT(4), .DIV_LAT(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .aluop_i(aluop_i),
        .funct_i(funct_i), .flush_i(flush_i), .aluctrl_o(aluctrl), .start_o(start),
        .stall_o(stall), .done_o(done), .busy_o(busy), .illegal_o(illegal)
    );

    // Wider control and single-cycle MUL, to cover zero-extension and LAT==1.
    alu_ctrl_seq #(.CTRL_W(4), .MUL_LAT(1), .DIV_LAT(8)) dutLat1 (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .aluop_i(aluop_i),
        .funct_i(funct_i), .flush_i(flush_i), .aluctrl_o(aluctrl1), .start_o(start1),
        .stall_o(stall1), .done_o(done1), .busy_o(busy1), .illegal_o(illegal1)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [8:0] mkExp(input logic [3:0] ctrl, input logic st,
                                         input logic sl, input logic dn,
                                         input logic bz, input logic il);
        return {ctrl, st, sl, dn, bz, il};
    endfunction

    function automatic logic [8:0] mainOut();
        return {1'b0, aluctrl, start, stall, done, busy, illegal};
    endfunction

    function automatic logic [8:0] lat1Out();
        return {aluctrl1, start1, stall1, done1, busy1, illegal1};
    endfunction

    task automatic applyStimulus(input logic v, input logic [1:0] op,
                                 input logic [5:0] f, input logic fl);
        valid_i = v;
        aluop_i = op;
        funct_i = f;
        flush_i = fl;
    endtask

    task automatic checkOutput(input string name, input logic [8:0] act,
                               input logic [8:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got ctrl=%b start=%b stall=%b done=%b busy=%b illegal=%b, expected ctrl=%b start=%b stall=%b done=%b busy=%b illegal=%b",
                     name, act[8:5], act[4], act[3], act[2], act[1], act[0],
                     exp[8:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        vecs[0]  = '{"rtype_sub",      1, 2'b11, 6'b100010, 0, mkExp(4'b0110, 0, 0, 0, 0, 0)};
        vecs[1]  = '{"rtype_add",      1, 2'b11, 6'b100000, 0, mkExp(4'b0010, 0, 0, 0, 0, 0)};
        vecs[2]  = '{"rtype_and",      1, 2'b11, 6'b100100, 0, mkExp(4'b0000, 0, 0, 0, 0, 0)};
        vecs[3]  = '{"rtype_or",       1, 2'b11, 6'b100101, 0, mkExp(4'b0001, 0, 0, 0, 0, 0)};
        vecs[4]  = '{"aluop_or",       1, 2'b00, 6'b111111, 0, mkExp(4'b0001, 0, 0, 0, 0, 0)};
        vecs[5]  = '{"aluop_add",      1, 2'b01, 6'b011000, 0, mkExp(4'b0010, 0, 0, 0, 0, 0)};
        vecs[6]  = '{"aluop_sub",      1, 2'b10, 6'b011010, 0, mkExp(4'b0110, 0, 0, 0, 0, 0)};
        vecs[7]  = '{"illegal_valid",  1, 2'b11, 6'b111111, 0, mkExp(4'b0010, 0, 0, 0, 0, 1)};
        vecs[8]  = '{"illegal_nvalid", 0, 2'b11, 6'b111111, 0, mkExp(4'b0010, 0, 0, 0, 0, 0)};
        vecs[9]  = '{"mul_not_valid",  0, 2'b11, 6'b011000, 0, mkExp(4'b0011, 0, 0, 0, 0, 0)};
        vecs[10] = '{"div_flushed",    1, 2'b11, 6'b011010, 1, mkExp(4'b0100, 0, 0, 0, 0, 0)};

        rst_i = 1'b1;
        applyStimulus(1, 2'b11, 6'b011010, 0);
        #2;
        checkOutput("reset_main", mainOut(), mkExp(4'b0010, 0, 0, 0, 0, 0));
        checkOutput("reset_lat1", lat1Out(), mkExp(4'b0010, 0, 0, 0, 0, 0));
        applyStimulus(0, 2'b01, 6'b000000, 0);
        nextCycle();
        rst_i = 1'b0;

        // Single-cycle decode table; none of these launch the sequencer.
        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].valid, vecs[i].aluop, vecs[i].funct, vecs[i].flush);
            @(negedge clk_i);
            checkOutput(vecs[i].name, mainOut(), vecs[i].exp);
            nextCycle();
        end

        // MUL with latency 4; funct changes during BUSY must be ignored.
        applyStimulus(1, 2'b11, 6'b011000, 0);
        @(negedge clk_i);
        checkOutput("mul_c0", mainOut(), mkExp(4'b0011, 1, 1, 0, 0, 0));
        for (int c = 1; c <= 3; c++) begin
            nextCycle();
            applyStimulus(1, 2'b11, 6'b100100, 0);
            @(negedge clk_i);
            if (c < 3) checkOutput($sformatf("mul_c%0d", c), mainOut(), mkExp(4'b0011, 0, 1, 0, 1, 0));
            else       checkOutput("mul_c3_done", mainOut(), mkExp(4'b0011, 0, 0, 1, 1, 0));
        end
        nextCycle();
        applyStimulus(1, 2'b01, 6'b000000, 0);
        @(negedge clk_i);
        checkOutput("mul_after_idle", mainOut(), mkExp(4'b0010, 0, 0, 0, 0, 0));
        nextCycle();

        // DIV (8) immediately followed by MUL (4): 7 + 3 stall cycles.
        stallCount = 0;
        for (int c = 0; c < 12; c++) begin
            if (c < 8) applyStimulus(1, 2'b11, 6'b011010, 0);
            else       applyStimulus(1, 2'b11, 6'b011000, 0);
            @(negedge clk_i);
            if (stall) stallCount++;
            case (c)
                0:       checkOutput("divmul_c0",  mainOut(), mkExp(4'b0100, 1, 1, 0, 0, 0));
                7:       checkOutput("divmul_c7",  mainOut(), mkExp(4'b0100, 0, 0, 1, 1, 0));
                8:       checkOutput("divmul_c8",  mainOut(), mkExp(4'b0011, 1, 1, 0, 0, 0));
                9, 10:   checkOutput($sformatf("divmul_c%0d", c), mainOut(), mkExp(4'b0011, 0, 1, 0, 1, 0));
                11:      checkOutput("divmul_c11", mainOut(), mkExp(4'b0011, 0, 0, 1, 1, 0));
                default: checkOutput($sformatf("divmul_c%0d", c), mainOut(), mkExp(4'b0100, 0, 1, 0, 1, 0));
            endcase
            nextCycle();
        end
        testsRun++;
        if (stallCount != 10) begin
            failCount++;
            $display("[TB] FAIL divmul_stall_total: got %0d stall cycles, expected 10", stallCount);
        end

        // MUL flushed on cycle 2: no done, ADD decodes on cycle 3.
        applyStimulus(1, 2'b11, 6'b011000, 0);
        @(negedge clk_i);
        checkOutput("flush_c0", mainOut(), mkExp(4'b0011, 1, 1, 0, 0, 0));
        nextCycle();
        @(negedge clk_i);
        checkOutput("flush_c1", mainOut(), mkExp(4'b0011, 0, 1, 0, 1, 0));
        nextCycle();
        flush_i = 1'b1;
        @(negedge clk_i);
        checkOutput("flush_c2", mainOut(), mkExp(4'b0011, 0, 0, 0, 1, 0));
        nextCycle();
        applyStimulus(1, 2'b01, 6'b000000, 0);
        for (int c = 3; c <= 5; c++) begin
            @(negedge clk_i);
            checkOutput($sformatf("flush_c%0d", c), mainOut(), mkExp(4'b0010, 0, 0, 0, 0, 0));
            nextCycle();
        end

        // Asynchronous reset in the middle of a DIV.
        applyStimulus(1, 2'b11, 6'b011010, 0);
        for (int c = 0; c < 3; c++) nextCycle();
        @(negedge clk_i);
        checkOutput("rstdiv_busy", mainOut(), mkExp(4'b0100, 0, 1, 0, 1, 0));
        #2;
        rst_i = 1'b1;
        #1;
        checkOutput("rstdiv_async", mainOut(), mkExp(4'b0010, 0, 0, 0, 0, 0));
        nextCycle();
        rst_i = 1'b0;
        applyStimulus(0, 2'b01, 6'b000000, 0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            checkOutput($sformatf("rstdiv_after%0d", c), mainOut(), mkExp(4'b0010, 0, 0, 0, 0, 0));
            nextCycle();
        end

        // MUL_LAT=1 build: start and done together, no stall, stays IDLE.
        applyStimulus(1, 2'b11, 6'b011000, 0);
        @(negedge clk_i);
        checkOutput("lat1_mul", lat1Out(), mkExp(4'b0011, 1, 0, 1, 0, 0));
        nextCycle();
        applyStimulus(1, 2'b01, 6'b000000, 0);
        @(negedge clk_i);
        checkOutput("lat1_after", lat1Out(), mkExp(4'b0010, 0, 0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
